// File: rtl/boot_stage_sequencer_if.sv
// Boot-side bus bundle of the sequencer: UART TX/RX byte paths and the
// instruction-memory byte write port. master = sequencer, slave = host side.
interface boot_stage_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_wdata;

  modport master (
    input  tx_ready,
    input  rx_valid,
    input  rx_data,
    output tx_valid,
    output tx_data,
    output prog_we,
    output prog_addr,
    output prog_wdata
  );

  modport slave (
    output tx_ready,
    output rx_valid,
    output rx_data,
    input  tx_valid,
    input  tx_data,
    input  prog_we,
    input  prog_addr,
    input  prog_wdata
  );
endinterface

// File: rtl/boot_stage_sequencer.sv
// Top control FSM of the multicycle core: UART boot handshake, then
// NUM_STAGES compute/latch phases with stall and sticky halt.
// Ports: clk, reset (async, active high), bus (boot UART/prog bus),
// stall/halt in; pipe_reset, io_enable, latch_en, mem/reg commit,
// running, boot_error out.
module boot_stage_sequencer #(
  parameter int         NUM_STAGES = 5,
  parameter int         MEM_STAGE  = 3,
  parameter int         WB_STAGE   = 4,
  parameter int         ADDR_W     = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'h99,
  parameter logic [7:0] DONE_BYTE  = 8'hAA
) (
  input  logic                  clk,
  input  logic                  reset,
  boot_stage_sequencer_if.master bus,
  input  logic                  stall,
  input  logic                  halt,
  output logic                  pipe_reset,
  output logic                  io_enable,
  output logic [NUM_STAGES-1:0] latch_en,
  output logic                  mem_commit_en,
  output logic                  reg_commit_en,
  output logic                  running,
  output logic                  boot_error
);

  localparam int PW = $clog2(2 * NUM_STAGES);
  localparam logic [PW-1:0] P_LAST = PW'(2 * NUM_STAGES - 1);
  localparam logic [PW-1:0] P_MEM  = PW'(2 * MEM_STAGE);
  localparam logic [PW-1:0] P_WB   = PW'(2 * WB_STAGE);
  localparam logic [32:0]   SZ_MAX = 33'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_INIT,
    S_TX_SYNC,
    S_RX_SIZE,
    S_RX_PROG,
    S_TX_DONE,
    S_RUN,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [32:0]     size_q;
  logic [1:0]      sbyte_q;
  logic [ADDR_W:0] cnt_q;
  logic [PW-1:0]   phase_q;

  logic [32:0]     size_full;
  logic            tx_fire;
  logic            last_byte;
  logic            run_go;

  // Size as it stands once the fourth (most significant) byte lands.
  assign size_full = {1'b0, bus.rx_data, size_q[23:0]};
  assign tx_fire   = bus.tx_valid && bus.tx_ready;
  assign last_byte = (33'(cnt_q) + 33'd1) == size_q;
  assign run_go    = (state_q == S_RUN) && !stall && !halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: begin
        state_d = S_TX_SYNC;
      end
      S_TX_SYNC: begin
        if (tx_fire) state_d = S_RX_SIZE;
      end
      S_RX_SIZE: begin
        if (bus.rx_valid && sbyte_q == 2'd3) begin
          if (size_full == 33'd0)
            state_d = S_TX_DONE;
          else if (size_full > SZ_MAX)
            state_d = S_ERROR;
          else
            state_d = S_RX_PROG;
        end
      end
      S_RX_PROG: begin
        if (bus.rx_valid && last_byte)
          state_d = S_TX_DONE;
      end
      S_TX_DONE: begin
        if (tx_fire) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt) state_d = S_HALTED;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Boot counters and run phase; phase only moves in RUN, so it is
  // still zero from reset when RUN is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q  <= '0;
      sbyte_q <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      if (state_q == S_RX_SIZE && bus.rx_valid) begin
        size_q[{sbyte_q, 3'b000} +: 8] <= bus.rx_data;
        sbyte_q <= sbyte_q + 2'd1;
      end
      if (state_q == S_RX_PROG && bus.rx_valid)
        cnt_q <= cnt_q + 1'b1;
      if (run_go)
        phase_q <= (phase_q == P_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  always_comb begin
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = cnt_q[ADDR_W-1:0];
    bus.prog_wdata = 8'h00;
    pipe_reset     = 1'b1;
    io_enable      = 1'b0;
    latch_en       = '0;
    mem_commit_en  = 1'b0;
    reg_commit_en  = 1'b0;
    running        = 1'b0;
    boot_error     = 1'b0;
    unique case (state_q)
      S_TX_SYNC: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = SYNC_BYTE;
      end
      S_RX_PROG: begin
        bus.prog_we = bus.rx_valid;
        if (bus.rx_valid)
          bus.prog_wdata = bus.rx_data;
      end
      S_TX_DONE: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = DONE_BYTE;
      end
      S_RUN: begin
        pipe_reset = 1'b0;
        io_enable  = 1'b1;
        running    = 1'b1;
        // Stall and halt both squash every enable this cycle.
        if (run_go) begin
          if (phase_q[0])
            latch_en = NUM_STAGES'(1) << (phase_q >> 1);
          mem_commit_en = (phase_q == P_MEM);
          reg_commit_en = (phase_q == P_WB);
        end
      end
      S_HALTED: begin
        pipe_reset = 1'b0;
      end
      S_ERROR: begin
        boot_error = 1'b1;
      end
      default: begin
        pipe_reset = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_boot_stage_sequencer.sv
// Self-checking bench for boot_stage_sequencer: randomized boot traffic
// and run-phase stall/halt against a phase-arithmetic reference model.
module tb_boot_stage_sequencer;
  localparam int N  = 5;
  localparam int MS = 3;
  localparam int WS = 4;
  localparam int AW = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic         halt = 1'b0;
  logic         pipe_reset;
  logic         io_enable;
  logic [N-1:0] latch_en;
  logic         mem_commit_en;
  logic         reg_commit_en;
  logic         running;
  logic         boot_error;

  int unsigned  n_chk = 0;
  int unsigned  n_err = 0;

  boot_stage_sequencer_if #(.ADDR_W(AW)) bus ();

  boot_stage_sequencer #(
    .NUM_STAGES(N),
    .MEM_STAGE (MS),
    .WB_STAGE  (WS),
    .ADDR_W    (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .stall        (stall),
    .halt         (halt),
    .pipe_reset   (pipe_reset),
    .io_enable    (io_enable),
    .latch_en     (latch_en),
    .mem_commit_en(mem_commit_en),
    .reg_commit_en(reg_commit_en),
    .running      (running),
    .boot_error   (boot_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_txv"}, bus.tx_valid, 0);
    check({tag, "_txd"}, bus.tx_data, 0);
    check({tag, "_we"}, bus.prog_we, 0);
    check({tag, "_addr"}, bus.prog_addr, 0);
    check({tag, "_prst"}, pipe_reset, 1);
    check({tag, "_io"}, io_enable, 0);
    check({tag, "_latch"}, latch_en, 0);
    check({tag, "_mem"}, mem_commit_en, 0);
    check({tag, "_reg"}, reg_commit_en, 0);
    check({tag, "_run"}, running, 0);
    check({tag, "_err"}, boot_error, 0);
  endtask

  task automatic rx_gap(input int gap, input string tag);
    repeat (gap) begin
      @(negedge clk);
      check(tag, bus.prog_we, 0);
      step();
    end
  endtask

  task automatic boot(input logic [31:0] sz, input int hold,
                      input int abort_at);
    logic [7:0] dir [3];
    logic [7:0] b;
    dir = '{8'h11, 8'h22, 8'h33};
    reset = 1'b1;
    stall = 1'b0;
    halt = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    #1;
    chk_reset_vals("rst");
    step();
    reset = 1'b0;
    @(negedge clk);
    check("init_txv", bus.tx_valid, 0);
    check("init_prst", pipe_reset, 1);
    step();
    repeat (hold) begin
      @(negedge clk);
      check("sync_hold_v", bus.tx_valid, 1);
      check("sync_hold_d", bus.tx_data, 32'h99);
      step();
    end
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'($urandom);
    @(negedge clk);
    check("sync_v", bus.tx_valid, 1);
    check("sync_d", bus.tx_data, 32'h99);
    check("sync_we", bus.prog_we, 0);
    check("sync_prst", pipe_reset, 1);
    step();
    bus.rx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rx_gap($urandom_range(0, 2), "size_gap_we");
      bus.rx_valid = 1'b1;
      bus.rx_data = sz[8*k +: 8];
      @(negedge clk);
      check("size_txv", bus.tx_valid, 0);
      check("size_we", bus.prog_we, 0);
      check("size_prst", pipe_reset, 1);
      step();
      bus.rx_valid = 1'b0;
    end
    if (sz > 32'h0001_0000) begin
      repeat (4) begin
        bus.rx_valid = 1'($urandom);
        bus.rx_data = 8'($urandom);
        @(negedge clk);
        check("err_flag", boot_error, 1);
        check("err_txv", bus.tx_valid, 0);
        check("err_we", bus.prog_we, 0);
        check("err_prst", pipe_reset, 1);
        check("err_run", running, 0);
        step();
      end
      bus.rx_valid = 1'b0;
      return;
    end
    for (int i = 0; i < int'(sz); i++) begin
      b = (sz == 32'd3) ? dir[i] : 8'($urandom);
      rx_gap($urandom_range(0, 2), "prog_gap_we");
      bus.rx_valid = 1'b1;
      bus.rx_data = b;
      @(negedge clk);
      check("prog_we", bus.prog_we, 1);
      check("prog_addr", bus.prog_addr, i);
      check("prog_wdata", bus.prog_wdata, b);
      check("prog_txv", bus.tx_valid, 0);
      step();
      bus.rx_valid = 1'b0;
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk_reset_vals("abort");
        step();
        reset = 1'b0;
        return;
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'($urandom);
    @(negedge clk);
    check("done_v", bus.tx_valid, 1);
    check("done_d", bus.tx_data, 32'hAA);
    check("done_we", bus.prog_we, 0);
    check("done_run", running, 0);
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_cycle(input bit s, inout int p);
    logic [N-1:0] e;
    e = '0;
    if (!s && (p % 2) == 1) e[p/2] = 1'b1;
    stall = s;
    bus.rx_valid = 1'($urandom);
    bus.rx_data = 8'($urandom);
    @(negedge clk);
    check("run_running", running, 1);
    check("run_io", io_enable, 1);
    check("run_prst", pipe_reset, 0);
    check("run_we", bus.prog_we, 0);
    check("run_latch", latch_en, e);
    check("run_mem", mem_commit_en, !s && p == 2 * MS);
    check("run_reg", reg_commit_en, !s && p == 2 * WS);
    step();
    if (!s) p = (p + 1) % (2 * N);
  endtask

  task automatic run_test(input int cycles, input bit directed);
    int p;
    int sdone;
    p = 0;
    sdone = 0;
    for (int c = 0; c < cycles; c++) begin
      if (directed) begin
        if (p == 5 && sdone < 3) begin
          sdone++;
          run_cycle(1'b1, p);
        end else begin
          run_cycle(1'b0, p);
        end
      end else begin
        run_cycle(($urandom % 4) == 0, p);
      end
    end
    while (p != 2) run_cycle(1'b0, p);
    halt = 1'b1;
    stall = 1'($urandom);
    @(negedge clk);
    check("halt_latch", latch_en, 0);
    check("halt_mem", mem_commit_en, 0);
    check("halt_reg", reg_commit_en, 0);
    check("halt_running", running, 1);
    step();
    repeat (3) begin
      halt = 1'($urandom);
      stall = 1'($urandom);
      @(negedge clk);
      check("hd_running", running, 0);
      check("hd_prst", pipe_reset, 0);
      check("hd_io", io_enable, 0);
      check("hd_latch", latch_en, 0);
      check("hd_mem", mem_commit_en, 0);
      step();
    end
    halt = 1'b0;
    stall = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    boot(32'd3, 5, -1);
    run_test(40, 1'b1);
    boot(32'd0, 0, -1);
    run_test(30, 1'b0);
    boot(32'h0001_0001, 2, -1);
    boot(32'($urandom_range(1, 24)), $urandom_range(0, 4), -1);
    run_test(50, 1'b0);
    boot(32'h0001_0000, 1, 3);
    @(negedge clk);
    check("post_abort_txv", bus.tx_valid, 0);
    check("post_abort_prst", pipe_reset, 1);
    step();
    @(negedge clk);
    check("post_abort_sync", bus.tx_data, 32'h99);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
